// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider job scheduler.
// FSM encoding, error codes and the post-start fini blanking length.
package div_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DIVZ = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    // The divider keeps fini high from the previous job for this many WAIT cycles.
    localparam int BLANK_CYCLES = 2;

endpackage

// File: rtl/div_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr_i, wrapping past NREQ-1.
// Latency: combinational. Backpressure: none, the caller decides when to take the grant.
// Produces a one-hot grant, its index and an any-request flag.
module div_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            vld_o
);

    logic           hi_found;
    logic [IDW-1:0] hi_idx;
    logic           lo_found;
    logic [IDW-1:0] lo_idx;

    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        // Descending scan leaves the lowest matching index in each candidate.
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(j);
                if (j >= int'(ptr_i)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(j);
                end
            end
        end
        vld_o = lo_found;
        idx_o = hi_found ? hi_idx : lo_idx;
        gnt_o = '0;
        for (int j = 0; j < NREQ; j++) begin
            gnt_o[j] = lo_found && (int'(idx_o) == j);
        end
    end

endmodule

// File: rtl/div_job_scheduler.sv
// Shares one serial divider between NREQ requesters; tagged result on a valid/ready channel.
// Latency: accept T, start T+1, result after divider fini (>= T+5); divide-by-zero answers at T+1.
// Backpressure: result held in RESP until rsp_ready_i; no accept while busy. Option: DIV_SCHED_TIMEOUT_EN.
module div_job_scheduler
    import div_sched_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int XLEN           = 32,
    parameter int IDW            = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*XLEN-1:0] req_dividend_i,
    input  logic [NREQ*XLEN-1:0] req_divisor_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [XLEN-1:0]      rsp_quotient_o,
    output logic [XLEN-1:0]      rsp_remainder_o,
    output logic [1:0]           rsp_err_o,
    output logic                 div_start_o,
    output logic [XLEN-1:0]      div_dividend_o,
    output logic [XLEN-1:0]      div_divisor_o,
    input  logic                 div_fini_i,
    input  logic [XLEN-1:0]      div_quotient_i,
    input  logic [XLEN-1:0]      div_remainder_i,
    output logic                 busy_o,
    output logic [15:0]          jobs_done_o
);

    state_t          state_q;
    logic [IDW-1:0]  rr_q;
    logic [IDW-1:0]  owner_q;
    logic [XLEN-1:0] dividend_q;
    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;
    logic [1:0]      err_q;
    logic            rsp_valid_q;
    logic [15:0]     jobs_q;
    logic [1:0]      blank_q;
    logic            fini_seen_q;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_vld;
    logic [XLEN-1:0] sel_dividend;
    logic [XLEN-1:0] sel_divisor;
    logic [IDW-1:0]  rr_d;
    logic [15:0]     jobs_d;
    logic            blank_done;
    logic            fini_valid;

`ifdef DIV_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] wait_cnt_q;
`endif

    div_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                sel_dividend = req_dividend_i[k*XLEN +: XLEN];
                sel_divisor  = req_divisor_i[k*XLEN +: XLEN];
            end
        end
    end

    assign rr_d       = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);
    assign jobs_d     = jobs_q + 16'd1;
    assign blank_done = (blank_q == 2'(BLANK_CYCLES));
    // Only a fini that has been seen low since start belongs to this job.
    assign fini_valid = blank_done && fini_seen_q && div_fini_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            err_q       <= ERR_NONE;
            rsp_valid_q <= 1'b0;
            jobs_q      <= '0;
            blank_q     <= '0;
            fini_seen_q <= 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        owner_q    <= gnt_idx;
                        dividend_q <= sel_dividend;
                        divisor_q  <= sel_divisor;
                        if (sel_divisor == '0) begin
                            quot_q      <= '1;
                            rem_q       <= sel_dividend;
                            err_q       <= ERR_DIVZ;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    blank_q     <= '0;
                    fini_seen_q <= 1'b0;
`ifdef DIV_SCHED_TIMEOUT_EN
                    wait_cnt_q  <= '0;
`endif
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!div_fini_i) begin
                        fini_seen_q <= 1'b1;
                    end
                    if (!blank_done) begin
                        blank_q <= blank_q + 2'd1;
                    end
`ifdef DIV_SCHED_TIMEOUT_EN
                    wait_cnt_q <= wait_cnt_q + TMO_W'(1);
`endif
                    if (fini_valid) begin
                        quot_q      <= div_quotient_i;
                        rem_q       <= div_remainder_i;
                        err_q       <= ERR_NONE;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
`ifdef DIV_SCHED_TIMEOUT_EN
                    else if (wait_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        quot_q      <= '0;
                        rem_q       <= '0;
                        err_q       <= ERR_TMO;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        jobs_q      <= jobs_d;
                        rr_q        <= rr_d;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o     = (state_q == ST_IDLE && !reset_i) ? gnt : '0;
    assign div_start_o     = (state_q == ST_ISSUE) && !reset_i;
    assign div_dividend_o  = dividend_q;
    assign div_divisor_o   = divisor_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_id_o        = owner_q;
    assign rsp_quotient_o  = quot_q;
    assign rsp_remainder_o = rem_q;
    assign rsp_err_o       = err_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign jobs_done_o     = jobs_q;

endmodule

// File: tb/tb_div_job_scheduler.sv
// Directed bench with a behavioural divider and a response scoreboard.
module tb_div_job_scheduler;

    localparam int NREQ = 2;
    localparam int XLEN = 32;
    localparam int IDW  = 3;
    localparam int TMO  = 64;
    localparam int DLAT = 5;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ*XLEN-1:0] req_dividend;
    logic [NREQ*XLEN-1:0] req_divisor;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [IDW-1:0]       rsp_id_o;
    logic [XLEN-1:0]      rsp_quotient_o;
    logic [XLEN-1:0]      rsp_remainder_o;
    logic [1:0]           rsp_err_o;
    logic                 div_start_o;
    logic [XLEN-1:0]      div_dividend_o;
    logic [XLEN-1:0]      div_divisor_o;
    logic                 div_fini;
    logic [XLEN-1:0]      div_q;
    logic [XLEN-1:0]      div_r;
    logic                 busy_o;
    logic [15:0]          jobs_done_o;

    always #5 clk = ~clk;

    div_job_scheduler #(
        .NREQ(NREQ), .XLEN(XLEN), .IDW(IDW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_dividend_i  (req_dividend),
        .req_divisor_i   (req_divisor),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_id_o        (rsp_id_o),
        .rsp_quotient_o  (rsp_quotient_o),
        .rsp_remainder_o (rsp_remainder_o),
        .rsp_err_o       (rsp_err_o),
        .div_start_o     (div_start_o),
        .div_dividend_o  (div_dividend_o),
        .div_divisor_o   (div_divisor_o),
        .div_fini_i      (div_fini),
        .div_quotient_i  (div_q),
        .div_remainder_i (div_r),
        .busy_o          (busy_o),
        .jobs_done_o     (jobs_done_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: fini drops the cycle after start, rises DLAT cycles later; divisor 1 never finishes.
    int          m_cnt;
    logic [31:0] m_dd, m_dv;
    always @(posedge clk) begin
        if (reset_i) begin
            m_cnt <= 0; div_fini <= 1'b0; div_q <= '0; div_r <= '0; m_dd <= '0; m_dv <= '0;
        end else if (div_start_o) begin
            div_fini <= 1'b0;
            m_dd     <= div_dividend_o;
            m_dv     <= div_divisor_o;
            m_cnt    <= (div_divisor_o == 32'd1) ? 0 : DLAT;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && m_dv != 0) begin
                div_fini <= 1'b1;
                div_q    <= m_dd / m_dv;
                div_r    <= m_dd % m_dv;
            end
        end
    end

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    q;
        logic [31:0]    r;
        logic [1:0]     err;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] q, input logic [31:0] r, input logic [1:0] e);
        exp_t x;
        x.id = IDW'(id); x.q = q; x.r = r; x.err = e;
        exp_q.push_back(x);
    endtask

    int start_cnt = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int hs_cyc = 0;
    int rdy_cnt[NREQ];
    initial for (int k = 0; k < NREQ; k++) rdy_cnt[k] = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (div_start_o) start_cnt++;
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready_o[k]) begin
                rdy_cnt[k]++;
                acc_cnt++;
                acc_cyc = cyc;
            end
        end
        if (rsp_valid_o && rsp_ready_i) begin
            hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d q %0h, no response expected", rsp_id_o, rsp_quotient_o);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id", 64'(rsp_id_o), 64'(e.id));
                chk("rsp_quotient", 64'(rsp_quotient_o), 64'(e.q));
                chk("rsp_remainder", 64'(rsp_remainder_o), 64'(e.r));
                chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
            end
        end
    end

    task automatic issue(input int k, input logic [31:0] dd, input logic [31:0] dv, output int t_acc);
        bit ok = 0;
        t_acc = 0;
        @(negedge clk);
        req_dividend[k*XLEN +: XLEN] = dd;
        req_divisor[k*XLEN +: XLEN]  = dv;
        req_valid[k] = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            #1;
            if (req_ready_o[k]) begin
                ok = 1;
                t_acc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        chk("accept", 64'(ok), 64'd1);
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk); #3;
            if (!busy_o && !rsp_valid_o) ok = 1;
        end
        chk("idle_within_budget", 64'(ok), 64'd1);
    endtask

    int t, h, base, s0, bad;
    logic [IDW-1:0]  snap_id;
    logic [31:0]     snap_q, snap_r;
    logic [1:0]      snap_e;

    initial begin
        reset_i = 1'b1; rsp_ready_i = 1'b1; req_valid = '0; req_dividend = '0; req_divisor = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        #3;
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 0);
        chk("rst_jobs", 64'(jobs_done_o), 0);
        chk("rst_start", 64'(div_start_o), 0);
        chk("rst_dividend", 64'(div_dividend_o), 0);
        chk("rst_err", 64'(rsp_err_o), 0);

        // Single job 100/4 from requester 0
        s0 = start_cnt; base = rdy_cnt[0];
        push(0, 25, 0, 2'b00);
        issue(0, 100, 4, t);
        wait_idle(50);
        chk("single_starts", 64'(start_cnt - s0), 1);
        chk("single_ready_pulses", 64'(rdy_cnt[0] - base), 1);
        chk("single_latency", 64'(hs_cyc - t), 8);
        chk("single_jobs", 64'(jobs_done_o), 1);
        chk("held_dividend", 64'(div_dividend_o), 100);
        chk("held_divisor", 64'(div_divisor_o), 4);

        // Divide by zero from requester 1
        s0 = start_cnt;
        push(1, 32'hFFFF_FFFF, 77, 2'b01);
        issue(1, 77, 0, t);
        wait_idle(20);
        chk("divz_starts", 64'(start_cnt - s0), 0);
        chk("divz_latency", 64'(hs_cyc - t), 1);
        chk("divz_jobs", 64'(jobs_done_o), 2);

        // Reset while waiting on the divider drops the job
        issue(0, 8, 3, t);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        #3;
        chk("midrst_busy", 64'(busy_o), 0);
        chk("midrst_rsp_valid", 64'(rsp_valid_o), 0);
        chk("midrst_jobs", 64'(jobs_done_o), 0);
        push(1, 4, 0, 2'b00);
        issue(1, 8, 2, t);
        wait_idle(50);
        chk("postrst_jobs", 64'(jobs_done_o), 1);

        // Both requesters held valid: four jobs alternate 0,1,0,1
        for (int i = 0; i < 2; i++) begin
            push(0, 8, 4, 2'b00);
            push(1, 11, 2, 2'b00);
        end
        base = acc_cnt;
        @(negedge clk);
        req_dividend = {32'd90, 32'd60};
        req_divisor  = {32'd8, 32'd7};
        req_valid    = 2'b11;
        for (int n = 0; n < 200 && acc_cnt < base + 4; n++) begin
            @(negedge clk); #3;
        end
        chk("rr_accepts", 64'(acc_cnt - base), 4);
        @(negedge clk);
        req_valid = '0;
        wait_idle(50);
        chk("rr_jobs", 64'(jobs_done_o), 5);

        // Backpressure: response held, pending request waits for the handshake
        rsp_ready_i = 1'b0;
        push(0, 8, 2, 2'b00);
        push(1, 10, 1, 2'b00);
        issue(0, 50, 6, t);
        req_dividend[XLEN +: XLEN] = 91;
        req_divisor[XLEN +: XLEN]  = 9;
        req_valid[1] = 1'b1;
        for (int n = 0; n < 50 && !rsp_valid_o; n++) begin
            @(negedge clk); #3;
        end
        chk("bp_rsp_valid", 64'(rsp_valid_o), 1);
        snap_id = rsp_id_o; snap_q = rsp_quotient_o; snap_r = rsp_remainder_o; snap_e = rsp_err_o;
        base = acc_cnt; bad = 0;
        repeat (10) begin
            @(negedge clk); #3;
            if (!rsp_valid_o || rsp_id_o != snap_id || rsp_quotient_o != snap_q ||
                rsp_remainder_o != snap_r || rsp_err_o != snap_e || req_ready_o != '0) bad++;
        end
        chk("bp_hold_stable", 64'(bad), 0);
        chk("bp_no_accept", 64'(acc_cnt - base), 0);
        @(negedge clk);
        rsp_ready_i = 1'b1;
        h = cyc;
        for (int n = 0; n < 20 && acc_cnt == base; n++) begin
            @(negedge clk); #3;
        end
        chk("bp_accept_after_hs", 64'(acc_cyc - h), 1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_idle(50);
        chk("bp_jobs", 64'(jobs_done_o), 7);

        // Divisor 1: the divider never raises fini
`ifdef DIV_SCHED_TIMEOUT_EN
        push(0, 0, 0, 2'b10);
        issue(0, 5, 1, t);
        wait_idle(200);
        chk("tmo_latency", 64'(hs_cyc - t), 64'(2 + TMO));
`else
        issue(0, 5, 1, t);
        repeat (100) @(negedge clk);
        #3;
        chk("nodone_busy", 64'(busy_o), 1);
        chk("nodone_rsp_valid", 64'(rsp_valid_o), 0);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        #3;
        chk("nodone_rst_busy", 64'(busy_o), 0);
`endif

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_job_scheduler.md
Name: div_job_scheduler

Overview:
- Shares one serial divider between NREQ requesters and sequences each job through it.
- Does round-robin arbitration, operand capture, a single-cycle start pulse, and completion detection on the divider's fini level.
- Returns a tagged result on a shared valid/ready response channel.
- Sits between the Wishbone/LA front-ends and the divider core.

Parameters:
- NREQ, 2, number of requesters (2..8)
- XLEN, 32, operand/result width
- IDW, 3, width of rsp_id_o (>= clog2(NREQ))
- TIMEOUT_CYCLES, 64, WAIT-state watchdog limit (used only with DIV_SCHED_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- req_valid_i  in  NREQ  per-requester job request
- req_ready_o  out  NREQ  one-hot acceptance pulse
- req_dividend_i  in  NREQ*XLEN  flattened; requester k in [k*XLEN +: XLEN]
- req_divisor_i  in  NREQ*XLEN  flattened, same packing
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result consumed
- rsp_id_o  out  IDW  requester index of the result
- rsp_quotient_o  out  XLEN  quotient
- rsp_remainder_o  out  XLEN  remainder
- rsp_err_o  out  2  bit0 divide-by-zero, bit1 timeout
- div_start_o  out  1  single-cycle start to divider
- div_dividend_o  out  XLEN  captured dividend, held stable IDLE-exit to next accept
- div_divisor_o  out  XLEN  captured divisor, same
- div_fini_i  in  1  divider done level (cleared by divider one cycle after start)
- div_quotient_i  in  XLEN  divider quotient
- div_remainder_i  in  XLEN  divider remainder
- busy_o  out  1  state != IDLE
- jobs_done_o  out  16  completed-response count, wraps 0xFFFF->0

Behaviour:
- Reset: state IDLE, rr pointer 0, all outputs 0 including captured operands and jobs_done_o.
- Reset mid-job drops the in-flight job; no response is produced; div_start_o is 0 in the reset cycle.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE, any req_valid_i set:
  - grant the first valid index at or after rr pointer, wrapping.
  - assert req_ready_o[g] for exactly that cycle.
  - capture dividend, divisor and owner g.
  - next state: RESP if divisor == 0, else ISSUE.
  - req_ready_o is 0 in all other states.
- Divide-by-zero result: quotient all-ones, remainder = dividend, err = 01. The divider is never started.
- ISSUE: div_start_o = 1 for one cycle -> WAIT. Clear fini_seen and the blank counter.
- WAIT: ignore div_fini_i for the first 2 cycles, because the divider's stale fini from the previous job is still high. After that, div_fini_i == 1:
  - capture div_quotient_i / div_remainder_i, err = 00.
  - -> RESP.
- RESP:
  - rsp_valid_o = 1 with id/quotient/remainder/err held stable until rsp_ready_i.
  - On the handshake cycle: jobs_done_o +1, rr pointer = owner+1 mod NREQ, -> IDLE.
- rsp_ready_i while rsp_valid_o = 0 is ignored.
- A requester may drop req_valid_i before it is granted; that is legal and the request is simply never accepted.
- Latency, nonzero divisor, rsp_ready_i held high: accept at cycle T, start at T+1, result valid at T+4+divider run time.
- Latency, zero divisor: rsp_valid_o at T+1.
- No new accept while busy; back-to-back jobs need one IDLE cycle.

Optional Feature:
- Macro: DIV_SCHED_TIMEOUT_EN.
- With macro: a WAIT cycle counter; reaching TIMEOUT_CYCLES with no valid fini -> RESP with quotient 0, remainder 0, err = 10. This covers divisor = 1, which this divider never finishes.
- Without macro: no counter, WAIT waits indefinitely, err bit1 is tied 0.

Decomposition:
- Package div_sched_pkg holds:
  - state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
  - error-code localparams.
  - the blank-cycle constant (2).
- One sub-module, div_rr_arbiter: combinational round-robin grant from req vector and pointer, producing one-hot grant and index.

Test Plan:
- Single job, requester 0 sends 100/4 -> one req_ready_o[0] pulse, one div_start_o pulse, response id 0, quotient 25, err 00, jobs_done_o = 1.
- Both requesters held valid continuously, 4 jobs (rsp_ready_i = 1) -> grants alternate 0,1,0,1 by rsp_id_o.
- Requester 1 sends 77/0 -> no div_start_o; rsp_valid_o 1 cycle after accept; quotient 0xFFFFFFFF, remainder 77, err 01.
- Hold rsp_ready_i = 0 for 10 cycles in RESP -> outputs stable; no accept despite pending req_valid_i; accept follows one cycle after the handshake.
- Assert reset_i during WAIT -> next cycle IDLE, rsp_valid_o 0, jobs_done_o 0; a following 8/2 job completes correctly with quotient 4.
- With DIV_SCHED_TIMEOUT_EN, send 5/1 -> err 10 exactly TIMEOUT_CYCLES cycles after entering WAIT. Without the macro, busy_o stays 1.
